lp805x_irqctl: RTL

Interrupt controller that consumes the per-peripheral interrupt flag/ready pairs (ntf/ntr-style outputs of the timer and other SFR peripherals), latches them as pending, arbitrates over two priority levels and presents one request plus vector index to the CPU core with a request/acknowledge handshake. It sits between the peripheral bank and the core's interrupt entry logic, and is itself an SFR-bus slave for enable, priority and pending registers.

---
 rtl/lp805x_irqctl_pkg.sv | 23 ++
 rtl/lp805x_irq_prienc.sv | 51 +++++
 rtl/lp805x_irqctl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/lp805x_irqctl_pkg.sv
// Shared definitions for the lp805x interrupt controller: SFR addresses,
// FSM state encoding and the IRQCTL status packing helper.
package lp805x_irqctl_pkg;

  localparam int LP805X_N_SRC = 8;

  localparam logic [7:0] LP805X_SFR_IRQCTL  = 8'he4;
  localparam logic [7:0] LP805X_SFR_IRQEN   = 8'he5;
  localparam logic [7:0] LP805X_SFR_IRQPRI  = 8'he6;
  localparam logic [7:0] LP805X_SFR_IRQPEND = 8'he7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } irq_state_e;

  // IRQCTL layout: EA, isr_hi, isr_lo, two zero bits, last acknowledged index.
  function automatic logic [7:0] irqctl_status(input logic ea, input logic isr_hi,
                                               input logic isr_lo, input logic [2:0] last);
    return {ea, isr_hi, isr_lo, 2'b00, last};
  endfunction

endpackage

// File: rtl/lp805x_irq_prienc.sv
// Two-level priority encoder: masks pending sources by enable, EA and the
// in-service level, then picks the lowest index of the highest level present.
module lp805x_irq_prienc
  import lp805x_irqctl_pkg::*;
#(
  parameter int N_SRC = LP805X_N_SRC
) (
  input  logic [N_SRC-1:0] pend_i,
  input  logic [N_SRC-1:0] en_i,
  input  logic [N_SRC-1:0] pri_i,
  input  logic             isr_hi_i,
  input  logic             isr_lo_i,
  input  logic             ea_i,
  output logic             valid_o,
  output logic [2:0]       idx_o
);

  logic [N_SRC-1:0] elig_s;
  logic [N_SRC-1:0] hi_s;
  logic [N_SRC-1:0] pick_s;
  logic [2:0]       idx_s;

  // A high-level handler blocks everything; a low-level one lets only high sources through.
  always_comb begin
    if (!ea_i || isr_hi_i) begin
      elig_s = '0;
    end else if (isr_lo_i) begin
      elig_s = pend_i & en_i & pri_i;
    end else begin
      elig_s = pend_i & en_i;
    end
    hi_s   = elig_s & pri_i;
    pick_s = (|hi_s) ? hi_s : elig_s;
  end

  // Scan downwards so the lowest set index is the last one written.
  always_comb begin
    idx_s = 3'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (pick_s[i]) begin
        idx_s = 3'(i);
      end else begin
        idx_s = idx_s;
      end
    end
  end

  assign valid_o = |pick_s;
  assign idx_o   = idx_s;

endmodule

// File: rtl/lp805x_irqctl.sv
// lp805x interrupt controller: pending latch, SFR registers, request/ack FSM
// towards the core and registered SFR read-back.
module lp805x_irqctl
  import lp805x_irqctl_pkg::*;
#(
  parameter int N_SRC = LP805X_N_SRC
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_i,
  input  logic             wr_bit_i,
  input  logic             rd_i,
  input  logic             rd_bit_i,
  input  logic [7:0]       wr_addr_i,
  input  logic [7:0]       rd_addr_i,
  input  logic [7:0]       data_in_i,
  input  logic             bit_in_i,
  output logic [7:0]       data_out_o,
  output logic             bit_out_o,
  input  logic [N_SRC-1:0] src_flag_i,
  input  logic [N_SRC-1:0] src_ready_i,
  output logic [N_SRC-1:0] src_clr_o,
  output logic             int_req_o,
  output logic [2:0]       int_vec_o,
  input  logic             int_ack_i,
  input  logic             int_reti_i
);

  irq_state_e       state_q, state_d;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [N_SRC-1:0] en_q, pri_q, clr_q;
  logic             ea_q, isr_hi_q, isr_lo_q, isr_hi_d, isr_lo_d;
  logic [2:0]       vec_q, last_q;
  logic [7:0]       rd_data_q;
  logic             rd_en_q;

  logic             arb_valid_s, ack_s, grant_s, withdraw_s, wr_byte_s;
  logic [2:0]       arb_idx_s;
  logic [N_SRC-1:0] set_s, clr_mask_s;
  logic [7:0]       rd_mux_s;
  logic             rd_hit_s;
  logic             unused_s;

  assign unused_s = ^{rd_i, rd_bit_i, bit_in_i};

  lp805x_irq_prienc #(.N_SRC(N_SRC)) u_prienc (
    .pend_i   (pend_q),
    .en_i     (en_q),
    .pri_i    (pri_q),
    .isr_hi_i (isr_hi_q),
    .isr_lo_i (isr_lo_q),
    .ea_i     (ea_q),
    .valid_o  (arb_valid_s),
    .idx_o    (arb_idx_s)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign withdraw_s = !pend_q[vec_q] || !en_q[vec_q] || !ea_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = arb_valid_s ? ST_REQ : ST_IDLE;
      ST_REQ:  state_d = (int_ack_i || withdraw_s) ? ST_IDLE : ST_REQ;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    int_req_o = (state_q == ST_REQ);
    ack_s     = (state_q == ST_REQ) && int_ack_i;
    grant_s   = (state_q == ST_IDLE) && arb_valid_s;
  end

  // Hardware set wins over both the SFR load and the acknowledge clear.
  assign wr_byte_s  = wr_i && !wr_bit_i;
  assign set_s      = src_flag_i & src_ready_i;
  assign clr_mask_s = ack_s ? (N_SRC'(1) << vec_q) : '0;
  assign pend_d     = ((wr_byte_s && wr_addr_i == LP805X_SFR_IRQPEND) ? data_in_i[N_SRC-1:0]
                                                                       : (pend_q & ~clr_mask_s))
                      | set_s;

  // reti retires the innermost level first, then an ack in the same cycle marks its level.
  assign isr_hi_d = (isr_hi_q && !int_reti_i) || (ack_s && pri_q[vec_q]);
  assign isr_lo_d = (isr_lo_q && !(int_reti_i && !isr_hi_q)) || (ack_s && !pri_q[vec_q]);

  always_comb begin
    rd_mux_s = 8'h00;
    rd_hit_s = 1'b1;
    case (rd_addr_i)
      LP805X_SFR_IRQCTL:  rd_mux_s = irqctl_status(ea_q, isr_hi_q, isr_lo_q, last_q);
      LP805X_SFR_IRQEN:   rd_mux_s = 8'(en_q);
      LP805X_SFR_IRQPRI:  rd_mux_s = 8'(pri_q);
      LP805X_SFR_IRQPEND: rd_mux_s = 8'(pend_q);
      default:            rd_hit_s = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q    <= '0;
      en_q      <= '0;
      pri_q     <= '0;
      ea_q      <= 1'b0;
      isr_hi_q  <= 1'b0;
      isr_lo_q  <= 1'b0;
      vec_q     <= 3'd0;
      last_q    <= 3'd0;
      clr_q     <= '0;
      rd_data_q <= 8'h00;
      rd_en_q   <= 1'b0;
    end else begin
      pend_q    <= pend_d;
      isr_hi_q  <= isr_hi_d;
      isr_lo_q  <= isr_lo_d;
      clr_q     <= clr_mask_s;
      rd_data_q <= rd_mux_s;
      rd_en_q   <= rd_hit_s;
      if (wr_byte_s && wr_addr_i == LP805X_SFR_IRQEN)  en_q  <= data_in_i[N_SRC-1:0];
      if (wr_byte_s && wr_addr_i == LP805X_SFR_IRQPRI) pri_q <= data_in_i[N_SRC-1:0];
      if (wr_byte_s && wr_addr_i == LP805X_SFR_IRQCTL) ea_q  <= data_in_i[7];
      if (grant_s) vec_q  <= arb_idx_s;
      if (ack_s)   last_q <= vec_q;
    end
  end

  assign src_clr_o  = clr_q;
  assign int_vec_o  = vec_q;
  assign data_out_o = rd_en_q ? rd_data_q : 8'hzz;
  assign bit_out_o  = 1'bz;

endmodule
